// File: rtl/sseg_capture_if.sv
// -----------------------------------------------------------------------------
// sseg_capture_if
// Bundles the multiplexed seven-segment bus being observed together with the
// decoded frame produced by the reader.
//   an         : digit selects, active-low, bit i = digit i
//   sseg       : segment lines, active-low, gfedcba
//   value      : last complete decoded frame, digit 0 in bits [3:0]
//   value_vld  : one-cycle pulse when value/err_mask/blank_mask update
//   err_mask   : digit showed a non-hex pattern in the last frame
//   blank_mask : digit was blank (all segments off) in the last frame
// master = display side (drives the bus, observes results)
// slave  = the reader
// -----------------------------------------------------------------------------
interface sseg_capture_if #(
  parameter int DIGITS = 4
);
  logic [DIGITS-1:0]   an;
  logic [6:0]          sseg;
  logic [4*DIGITS-1:0] value;
  logic                value_vld;
  logic [DIGITS-1:0]   err_mask;
  logic [DIGITS-1:0]   blank_mask;

  modport master (
    output an, sseg,
    input  value, value_vld, err_mask, blank_mask
  );

  modport slave (
    input  an, sseg,
    output value, value_vld, err_mask, blank_mask
  );
endinterface

// File: rtl/sseg_capture.sv
// -----------------------------------------------------------------------------
// sseg_capture
// Reads a time-multiplexed, active-low common-anode seven-segment bus back into
// hex nibbles. Each (digit, pattern) pair must be seen STABLE_CNT consecutive
// synchronized cycles before it is committed; once every digit has been
// committed the whole frame is published with per-digit error/blank flags.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sseg_capture_if.slave (an/sseg in, value/value_vld/masks out)
// -----------------------------------------------------------------------------
module sseg_capture #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  sseg_capture_if.slave  bus
);

  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_HELD} state_t;

  // Decoded digit: {err, blank, nibble}
  function automatic logic [5:0] f_decode(input logic [6:0] seg);
    unique case (seg)
      7'b1000000: f_decode = 6'h00;
      7'b1111001: f_decode = 6'h01;
      7'b0100100: f_decode = 6'h02;
      7'b0110000: f_decode = 6'h03;
      7'b0011001: f_decode = 6'h04;
      7'b0010010: f_decode = 6'h05;
      7'b0000010: f_decode = 6'h06;
      7'b1111000: f_decode = 6'h07;
      7'b0000000: f_decode = 6'h08;
      7'b0010000: f_decode = 6'h09;
      7'b0001000: f_decode = 6'h0A;
      7'b0000011: f_decode = 6'h0B;
      7'b1000110: f_decode = 6'h0C;
      7'b0100001: f_decode = 6'h0D;
      7'b0000110: f_decode = 6'h0E;
      7'b0001110: f_decode = 6'h0F;
      7'b1111111: f_decode = 6'b01_0000;
      default:    f_decode = 6'b10_0000;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // 2-flop synchronizers, idle (all ones) out of reset
  // ---------------------------------------------------------------------------
  logic [DIGITS-1:0] r_an_s1, r_an_s2;
  logic [6:0]        r_seg_s1, r_seg_s2;

  // NOTE: every register is assigned with <= so the second stage sees the
  // first stage's previous value; with = the two flops would collapse into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an_s1  <= '1;
      r_an_s2  <= '1;
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
    end else begin
      r_an_s1  <= bus.an;
      r_an_s2  <= r_an_s1;
      r_seg_s1 <= bus.sseg;
      r_seg_s2 <= r_seg_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample qualification: exactly one select low
  // ---------------------------------------------------------------------------
  logic [DIGITS-1:0] w_sel;
  logic              w_legal;
  logic [IW-1:0]     w_idx;

  assign w_sel   = ~r_an_s2;
  assign w_legal = (w_sel != '0) && ((w_sel & (w_sel - DIGITS'(1))) == '0);

  // NOTE: w_idx gets a default before the loop, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_sel[i]) w_idx = IW'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Stability FSM
  // ---------------------------------------------------------------------------
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [IW-1:0] r_idx;
  logic [6:0]    r_seg_lat;
  logic          w_same, w_start, w_latch, w_commit;

  assign w_same = (w_idx == r_idx) && (r_seg_s2 == r_seg_lat);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start     = 1'b0;
    w_latch     = 1'b0;
    w_commit    = 1'b0;
    if (!w_legal) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        S_TRACK: begin
          if (w_same) begin
            if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + CW'(1);
            if (r_cnt + CW'(1) == CNT_MAX) begin
              w_commit    = 1'b1;
              w_state_nxt = S_HELD;
            end
          end else begin
            w_start = 1'b1;
          end
        end
        // A held pair has already been committed; only a new pair restarts.
        S_HELD:  w_start = !w_same;
        default: w_start = 1'b1;
      endcase
    end
    if (w_start) begin
      w_cnt_nxt = CW'(1);
      w_latch   = 1'b1;
      if (STABLE_CNT == 1) begin
        w_commit    = 1'b1;
        w_state_nxt = S_HELD;
      end else begin
        w_state_nxt = S_TRACK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_seg_lat <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_idx     <= w_idx;
        r_seg_lat <= r_seg_s2;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow slots and frame assembly. On a commit the current synchronized pair
  // equals the tracked pair, so it is decoded directly.
  // ---------------------------------------------------------------------------
  logic [4*DIGITS-1:0] r_nib, w_nib_nxt;
  logic [DIGITS-1:0]   r_err, w_err_nxt;
  logic [DIGITS-1:0]   r_blank, w_blank_nxt;
  logic [DIGITS-1:0]   r_seen, w_seen_nxt;
  logic [5:0]          w_dec;
  logic                w_frame_done;

  assign w_dec = f_decode(r_seg_s2);

  always_comb begin
    w_nib_nxt   = r_nib;
    w_err_nxt   = r_err;
    w_blank_nxt = r_blank;
    w_seen_nxt  = r_seen;
    if (w_commit) begin
      w_nib_nxt[4*int'(w_idx) +: 4] = w_dec[3:0];
      w_blank_nxt[w_idx]            = w_dec[4];
      w_err_nxt[w_idx]              = w_dec[5];
      w_seen_nxt[w_idx]             = 1'b1;
    end
  end

  // The just-committed digit is merged in before publishing.
  assign w_frame_done = w_commit && (w_seen_nxt == '1);

  logic [4*DIGITS-1:0] r_value;
  logic [DIGITS-1:0]   r_err_mask, r_blank_mask;
  logic                r_value_vld;

  // NOTE: the shadow slots are reset only for determinism; clearing r_seen is
  // what actually discards a partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nib        <= '0;
      r_err        <= '0;
      r_blank      <= '0;
      r_seen       <= '0;
      r_value      <= '0;
      r_err_mask   <= '0;
      r_blank_mask <= '0;
      r_value_vld  <= 1'b0;
    end else begin
      r_nib       <= w_nib_nxt;
      r_err       <= w_err_nxt;
      r_blank     <= w_blank_nxt;
      r_seen      <= w_frame_done ? '0 : w_seen_nxt;
      r_value_vld <= w_frame_done;
      if (w_frame_done) begin
        r_value      <= w_nib_nxt;
        r_err_mask   <= w_err_nxt;
        r_blank_mask <= w_blank_nxt;
      end
    end
  end

  assign bus.value      = r_value;
  assign bus.value_vld  = r_value_vld;
  assign bus.err_mask   = r_err_mask;
  assign bus.blank_mask = r_blank_mask;

endmodule

// File: tb/tb_sseg_capture.sv
// -----------------------------------------------------------------------------
// tb_sseg_capture
// Directed stimulus for sseg_capture (DIGITS=4, STABLE_CNT=4). Expected frames
// are queued before each scan; a monitor pops one per value_vld pulse.
// -----------------------------------------------------------------------------
module tb_sseg_capture;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sseg_capture_if #(.DIGITS(4)) bus ();

  sseg_capture #(.DIGITS(4), .STABLE_CNT(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  err;
    logic [3:0]  blank;
  } exp_t;

  exp_t q_exp[$];
  int   checks    = 0;
  int   failures  = 0;
  int   vld_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: seg_of = 7'b1000000;
      4'h1: seg_of = 7'b1111001;
      4'h2: seg_of = 7'b0100100;
      4'h3: seg_of = 7'b0110000;
      4'h4: seg_of = 7'b0011001;
      4'h5: seg_of = 7'b0010010;
      4'h6: seg_of = 7'b0000010;
      4'h7: seg_of = 7'b1111000;
      4'h8: seg_of = 7'b0000000;
      4'h9: seg_of = 7'b0010000;
      4'hA: seg_of = 7'b0001000;
      4'hB: seg_of = 7'b0000011;
      4'hC: seg_of = 7'b1000110;
      4'hD: seg_of = 7'b0100001;
      4'hE: seg_of = 7'b0000110;
      default: seg_of = 7'b0001110;
    endcase
  endfunction

  // Monitor: one scoreboard entry per value_vld pulse
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.value_vld === 1'b1) begin
      vld_count++;
      if (q_exp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_vld: got value %0h with no expected frame", bus.value);
      end else begin
        exp_t e;
        e = q_exp.pop_front();
        check("frame_value", 32'(bus.value), 32'(e.value));
        check("frame_err", 32'(bus.err_mask), 32'(e.err));
        check("frame_blank", 32'(bus.blank_mask), 32'(e.blank));
      end
    end
  end

  // Called at a negedge; holds the pair for n rising edges.
  task automatic show(input int d, input logic [6:0] s, input int n);
    bus.an    = 4'b1111;
    bus.an[d] = 1'b0;
    bus.sseg  = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic gap(input int n);
    bus.an   = 4'b1111;
    bus.sseg = 7'b1111111;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [15:0] v, input int hold, input int gp);
    for (int d = 0; d < 4; d++) begin
      show(d, seg_of(v[4*d +: 4]), hold);
      if (gp > 0) gap(gp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.an   = '1;
    bus.sseg = '1;
    @(negedge clk);

    // Reset with random inputs
    for (int i = 0; i < 6; i++) begin
      bus.an   = 4'($urandom);
      bus.sseg = 7'($urandom);
      @(negedge clk);
    end
    check("rst_value", 32'(bus.value), 32'h0);
    check("rst_err", 32'(bus.err_mask), 32'h0);
    check("rst_blank", 32'(bus.blank_mask), 32'h0);
    check("rst_vld", 32'(bus.value_vld), 32'h0);
    rst_n = 1'b1;
    gap(2 + 4 + 2);
    check("rst_no_vld", vld_count, 0);

    // Clean scan
    q_exp.push_back('{16'h1A3F, 4'b0000, 4'b0000});
    frame(16'h1A3F, 8, 2);
    gap(6);
    check("clean_vld_count", vld_count, 1);

    // Glitch: a 3-cycle "2" on digit 1 must never commit
    q_exp.push_back('{16'h0010, 4'b0000, 4'b0000});
    show(0, seg_of(4'h0), 8); gap(2);
    show(1, seg_of(4'h2), 3);
    show(1, seg_of(4'h1), 8); gap(2);
    show(2, seg_of(4'h0), 8); gap(2);
    show(3, seg_of(4'h0), 8); gap(6);
    check("glitch_vld_count", vld_count, 2);

    // Invalid and blank digits
    q_exp.push_back('{16'h0075, 4'b0100, 4'b1000});
    show(0, seg_of(4'h5), 8); gap(2);
    show(1, seg_of(4'h7), 8); gap(2);
    show(2, 7'b1010101, 8);   gap(2);
    show(3, 7'b1111111, 8);   gap(6);
    check("inv_vld_count", vld_count, 3);
    check("inv_upper_byte", 32'(bus.value[15:8]), 32'h00);

    // Illegal select held long: nothing commits, outputs hold
    bus.an   = 4'b1100;
    bus.sseg = seg_of(4'h8);
    repeat (20) @(negedge clk);
    gap(4);
    check("illegal_vld_count", vld_count, 3);
    check("illegal_value_hold", 32'(bus.value), 32'h0075);
    check("illegal_err_hold", 32'(bus.err_mask), 32'h4);

    // Valid frame afterwards, digits out of order
    q_exp.push_back('{16'hEB98, 4'b0000, 4'b0000});
    show(3, seg_of(4'hE), 8); gap(2);
    show(1, seg_of(4'h9), 8); gap(2);
    show(0, seg_of(4'h8), 8); gap(2);
    show(2, seg_of(4'hB), 8); gap(6);
    check("order_vld_count", vld_count, 4);

    // Minimum hold (exactly STABLE_CNT), back-to-back frames, no gaps
    q_exp.push_back('{16'hF3A7, 4'b0000, 4'b0000});
    q_exp.push_back('{16'h8421, 4'b0000, 4'b0000});
    frame(16'hF3A7, 4, 0);
    frame(16'h8421, 4, 0);
    gap(6);
    check("b2b_vld_count", vld_count, 6);

    // Mid-frame reset discards partial slots
    show(0, seg_of(4'hC), 8); gap(2);
    show(1, seg_of(4'hD), 8); gap(2);
    show(2, seg_of(4'h6), 8); gap(2);
    rst_n = 1'b0;
    gap(2);
    check("midrst_value", 32'(bus.value), 32'h0);
    rst_n = 1'b1;
    gap(2);
    show(3, seg_of(4'h4), 8); gap(8);
    check("midrst_no_vld", vld_count, 6);
    q_exp.push_back('{16'h46DC, 4'b0000, 4'b0000});
    show(0, seg_of(4'hC), 8); gap(2);
    show(1, seg_of(4'hD), 8); gap(2);
    show(2, seg_of(4'h6), 8); gap(6);
    check("midrst_vld_count", vld_count, 7);
    check("midrst_value_final", 32'(bus.value), 32'h46DC);

    check("scoreboard_drained", q_exp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sseg_capture.md
# sseg_capture

Seven-segment display reader: samples a time-multiplexed, active-low common-anode seven-segment bus (digit selects plus gfedcba segment lines) and converts what is shown back into hex nibbles. It is the decode-side counterpart of the hex-to-segment encoders in the display path. It is used as an on-chip monitor and loopback checker for display drivers. Each digit is debounced by a stability counter, and one complete multi-digit value is reported per scan frame with per-digit error and blank flags.

## Interface
- `DIGITS`, default 4: number of multiplexed digits (1..8).
- `STABLE_CNT`, default 4: consecutive identical samples required to accept a digit (1..255).
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `an`, input, `DIGITS`: digit selects, active-low; bit i = digit i, where digit 0 is the least-significant nibble.
- `sseg`, input, 7: segment lines, active-low, arranged as gfedcba.
- `value`, output, `4*DIGITS`: last complete decoded frame.
- `value_vld`, output, 1: one-cycle pulse when `value` and the masks update.
- `err_mask`, output, `DIGITS`: bit i set if digit i showed a non-hex pattern in the last frame.
- `blank_mask`, output, `DIGITS`: bit i set if digit i was blank (all segments off) in the last frame.

## Operation
- Input synchronization
  - `an` and `sseg` each pass through a 2-flop synchronizer.
  - Synchronizer reset value is all ones (inactive).
  - All logic below sees the synchronized copies only.
- Sample qualification
  - A sample is legal when exactly one bit of `an` is 0; its index is `idx`.
  - `an` all ones is a blanking gap. More than one 0 is illegal.
  - Gaps and illegal samples are both ignored, and the FSM returns to IDLE.
- FSM states: IDLE, TRACK, HELD.
  - IDLE + legal sample: cnt <= 1, latch the (`idx`, `sseg`) pair, go to TRACK. If `STABLE_CNT` = 1, commit immediately and go to HELD.
  - TRACK + same pair: cnt increments. When cnt reaches `STABLE_CNT`, commit and go to HELD.
  - TRACK + different legal pair: cnt <= 1, latch the new pair, stay in TRACK (with `STABLE_CNT` = 1, this commits at once instead).
  - HELD + same pair: no action. A held pair is committed exactly once.
  - HELD + different legal pair: same as IDLE + legal sample.
  - TRACK or HELD + gap or illegal sample: go to IDLE, cnt <= 0.
- Commit of digit `idx` writes shadow slot `idx` and sets `seen[idx]`. Decode rules:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000.
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
  - 1111111: nibble 0, blank bit 1, err bit 0.
  - Any other pattern: nibble 0, err bit 1, blank bit 0.
  - Recommitting a digit before the frame completes overwrites its slot.
- Frame completion
  - Occurs when `seen` becomes all ones, including on the commit that sets the last bit.
  - `value`, `err_mask` and `blank_mask` load from the shadow slots, with the just-committed digit included.
  - `value_vld` pulses and `seen` clears.
  - Digits may arrive in any order.
- Outputs change only at frame completion and at reset.

## Timing
- Reset state: `value` = 0, `err_mask` = 0, `blank_mask` = 0, `value_vld` = 0, `seen` = 0, FSM in IDLE, cnt = 0.
- A reset asserted mid-frame discards partial slots. The first `value_vld` after reset needs a full new frame.
- Suppose a new pair reaches the input pins before edge E and stays stable:
  - It appears at the synchronizer output after edge E+1.
  - The commit occurs at edge E+1+`STABLE_CNT`.
  - If that commit completes the frame, the outputs update and `value_vld` is high for the cycle that follows this edge.
- Pairs stable for fewer than `STABLE_CNT` synchronized cycles are never committed.
- Back-to-back frames: `value_vld` may pulse on consecutive frames. There is no minimum gap other than `DIGITS` commits.
- cnt width is ceil(log2(`STABLE_CNT`+1)); cnt saturates and never wraps.

## Test plan
- Reset: hold `rst_n` low with random inputs -> all outputs 0; no `value_vld` for 2+`STABLE_CNT` cycles after release while `an` = 1111.
- Clean scan, defaults: digits 0..3 show F, 3, A, 1 (1111 gaps of 2 cycles), each held 8 cycles -> exactly one `value_vld`, `value` = 16'h1A3F, `err_mask` = 0, `blank_mask` = 0.
- Glitch: digit 1 shows 0100100 for 3 cycles then 1111001 for 8 cycles; other digits show 0 -> `value` = 16'h0010, with 2 never committed.
- Invalid and blank: digit 2 shows 1010101 and digit 3 shows 1111111 -> `err_mask` = 4'b0100, `blank_mask` = 4'b1000, `value[15:8]` = 8'h00.
- Illegal select: `an` = 1100 held 20 cycles -> no commit, no `value_vld`. After that, a valid frame decodes normally.
- Mid-frame reset: commit digits 0..2, pulse `rst_n` low, then send only digit 3 -> no `value_vld` until digits 0..2 are resent.
